out_port_seg_bcd: RTL
=====================

Name: out_port_seg_bcd

Overview:
Parametrised decimal seven-segment output port for the CPU I/O subsystem: latches a binary value on a write strobe, converts it to DIGITS BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives DIGITS seven-segment displays.
- Adds over the fixed 2-digit port: generic width and digit count, overflow indication, optional leading-zero blanking, selectable segment polarity, a busy/done handshake and a one-deep pending-write buffer.

Parameters:
- DATA_W, 32, width of datain; legal range 4..32.
- DIGITS, 2, number of decimal digits displayed; legal range 1..9.
- BLANK_LZ, 0, 1 = blank leading zero digits (digit 0 always shown).
- ACTIVE_LOW, 1, 1 = segment on is 0 (board default); 0 = all segment outputs inverted.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  write strobe; datain is sampled on the clock edge where we=1.
- datain  in  DATA_W  unsigned binary value.
- hex  out  7*DIGITS  segment bus; digit i is hex[7i+6:7i], bit order {g,f,e,d,c,b,a}; digit 0 is the units digit.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse; hex was updated on this edge.
- ovf  out  1  last completed value exceeded 10^DIGITS-1.

Behaviour:
- Reset (asynchronous, any state): FSM=IDLE, hex=all digits blank (7'h7F each with ACTIVE_LOW=1), busy=0, done=0, ovf=0, pending flag cleared. Any in-flight conversion is discarded.
- Segment codes with ACTIVE_LOW=1:
  - Digits 0..9 = 40,79,24,30,19,12,02,78,00,10 (hex).
  - Blank = 7F. Dash = 3F (segment g only).
  - ACTIVE_LOW=0 inverts every bit of hex.
- FSM states: IDLE, CONV, UPDATE.
- IDLE:
  - we=1: load datain into the shift register, clear the BCD register and the shift counter, go to CONV, busy=1.
  - Else, pending flag set: load the pending data, clear the flag, go to CONV.
  - we has priority; a we in IDLE also clears the pending flag (newest data wins).
- CONV: one shift per cycle for exactly DATA_W cycles. Each cycle:
  - Add 3 to every BCD nibble >=5.
  - Shift {bcd,bin} left by 1.
  - After the DATA_W-th shift, go to UPDATE.
- UPDATE: one cycle.
  - Register hex from the BCD register, pulse done=1, set ovf, clear busy, return to IDLE.
- Latency: we sampled at edge k, then busy=1 from edge k, CONV shifts at edges k+1..k+DATA_W, hex/done/ovf updated at edge k+DATA_W+1 (busy=0 at that edge).
- Overflow: evaluated at load time as value > 10^DIGITS-1 (constant).
  - If set, UPDATE drives every digit to Dash and ovf=1.
  - ovf holds until the next UPDATE of an in-range value.
  - If 2^DATA_W-1 <= 10^DIGITS-1, ovf is constant 0.
- BCD register is 4*DIGITS bits. Bits shifted out of the top nibble are discarded; this is only reachable when ovf=1.
- Leading-zero blanking (BLANK_LZ=1):
  - Digits above the most-significant nonzero digit are Blank.
  - Value 0 shows Blank except digit 0, which shows "0".
  - Not applied when ovf.
- Writes while busy (CONV or UPDATE): datain is stored in the pending register and the pending flag is set. A later write while busy overwrites the pending value (one-deep, last wins).
- Pending start: a pending value starts in IDLE on the cycle after UPDATE, so back-to-back conversions have one IDLE cycle between them.
- done and busy are never both 1. hex never changes outside UPDATE or reset.

Decomposition:
- Package seg_pkg contains:
  - Segment constants SEG_BLANK, SEG_DASH.
  - The 10-entry digit code table.
  - Constant function pow10_minus1(DIGITS).
  - FSM state encoding.
- Sub-module seg7_digit_enc: combinational 4-bit BCD to 7-bit code with ACTIVE_LOW and blank inputs. Instantiated DIGITS times in a generate loop.

Test Plan:
- Reset: assert reset mid-CONV (after datain=42 accepted) -> immediately hex=7F7F, busy=0, done=0, ovf=0; no done pulse afterwards.
- Basic, DIGITS=2, DATA_W=32: we with datain=42 at edge k -> busy high; at edge k+33 done=1 for one cycle, hex[13:7]=19, hex[6:0]=24, ovf=0.
- Overflow: datain=100 -> hex=3F,3F, ovf=1; then datain=99 -> hex=10,10, ovf=0.
- Blanking, BLANK_LZ=1: datain=7 -> hex[13:7]=7F, hex[6:0]=78; datain=0 -> 7F, 40.
- Pending buffer: write 12; during CONV write 34 then 56 -> exactly two done pulses showing 12 then 56; second conversion starts one cycle after first UPDATE; 34 never shown.
- DIGITS=4, ACTIVE_LOW=0: datain=9999 -> every digit ~10 = 6F; datain=10000 -> every digit ~3F = 40, ovf=1.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment codes, digit table, FSM encoding and helpers
//
// Purpose: constants and helpers for the decimal seven-segment output port.
// Segment codes are stored in the board's native active-low form with bit
// order {g,f,e,d,c,b,a}; polarity inversion is applied by the digit encoder.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Index 0 is the rightmost entry: digits 9..0 from left to right.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  // Largest value representable in n decimal digits (10^n - 1).
  function automatic logic [63:0] pow10_minus1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// rtl/seg7_digit_enc.sv - combinational BCD digit to seven-segment encoder
//
// Purpose: maps one BCD digit to its segment pattern, with blank and dash
// overrides. Dash wins over blank, blank wins over the digit.
// Ports:
//   digit  in   4  BCD digit (codes above 9 render as dash)
//   blank  in   1  force all segments off
//   dash   in   1  force segment g only (overflow indication)
//   seg    out  7  segment pattern {g,f,e,d,c,b,a} in output polarity
module seg7_digit_enc
  import seg_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  logic [6:0] code;

  always_comb begin
    code = SEG_BLANK;
    if (dash) begin
      code = SEG_DASH;
    end else if (blank) begin
      code = SEG_BLANK;
    end else if (digit <= 4'd9) begin
      code = SEG_TABLE[digit];
    end else begin
      code = SEG_DASH;
    end
    seg = (ACTIVE_LOW != 0) ? code : ~code;
  end

endmodule

// File: rtl/out_port_seg_bcd.sv
// rtl/out_port_seg_bcd.sv - decimal seven-segment output port with double-dabble
//
// Purpose: latches a binary value on a write strobe, converts it to DIGITS BCD
// digits one shift per cycle, then updates the segment bus in a single cycle.
// A one-deep pending buffer absorbs writes that arrive while busy.
// Ports:
//   clock   in   1         system clock, rising edge
//   reset   in   1         asynchronous active-high reset
//   we      in   1         write strobe
//   datain  in   DATA_W    unsigned binary value
//   hex     out  7*DIGITS  segment bus, digit i at hex[7i+6:7i], digit 0 = units
//   busy    out  1         conversion in progress
//   done    out  1         one-cycle pulse, hex updated on this edge
//   ovf     out  1         last completed value exceeded 10^DIGITS-1
module out_port_seg_bcd
  import seg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DIGITS     = 2,
  parameter int BLANK_LZ   = 0,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [DATA_W-1:0]     datain,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int          BCD_W      = 4 * DIGITS;
  localparam int          CNT_W      = $clog2(DATA_W);
  localparam logic [63:0] MAX_VAL    = pow10_minus1(DIGITS);
  localparam logic [6:0]  BLANK_CODE = (ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;

  state_t              state;
  logic [DATA_W-1:0]   bin;
  logic [DATA_W-1:0]   pend_data;
  logic                pend_valid;
  logic [BCD_W-1:0]    bcd;
  logic [CNT_W-1:0]    cnt;
  logic                conv_ovf;

  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W-1:0]    bcd_next;
  logic [DATA_W-1:0]   bin_next;
  logic [DATA_W-1:0]   load_val;
  logic [DIGITS-1:0]   blank;
  logic                lz_run;
  logic [7*DIGITS-1:0] seg_next;

  // Overflow is a property of the loaded value, so it is decided at load time
  // rather than from the (possibly truncated) BCD result.
  function automatic logic over_range(input logic [DATA_W-1:0] v);
    return 64'(v) > MAX_VAL;
  endfunction

  // A fresh write beats a pending one: newest data wins.
  assign load_val = we ? datain : pend_data;

  // One double-dabble step: correct nibbles >= 5, then shift {bcd,bin} left.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    bcd_next = {bcd_adj[BCD_W-2:0], bin[DATA_W-1]};
    bin_next = {bin[DATA_W-2:0], 1'b0};
  end

  // A digit above units is a leading zero when it and every digit above it
  // are zero. Digit 0 is never blanked.
  always_comb begin
    blank  = '0;
    lz_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run   = lz_run & (bcd[4*i +: 4] == 4'd0);
      blank[i] = (BLANK_LZ != 0) && lz_run;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_digit_enc #(
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_enc (
      .digit(bcd[4*g +: 4]),
      .blank(blank[g]),
      .dash (conv_ovf),
      .seg  (seg_next[7*g +: 7])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hex        <= {DIGITS{BLANK_CODE}};
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      bin        <= '0;
      bcd        <= '0;
      cnt        <= '0;
      conv_ovf   <= 1'b0;
    end else begin
      done <= 1'b0;

      // Writes while busy park in the pending slot; later ones overwrite it.
      if (we && (state != IDLE)) begin
        pend_data  <= datain;
        pend_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (we || pend_valid) begin
            bin        <= load_val;
            bcd        <= '0;
            cnt        <= '0;
            conv_ovf   <= over_range(load_val);
            pend_valid <= 1'b0;
            busy       <= 1'b1;
            state      <= CONV;
          end
        end
        CONV: begin
          bin <= bin_next;
          bcd <= bcd_next;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            state <= UPDATE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        UPDATE: begin
          hex   <= seg_next;
          done  <= 1'b1;
          ovf   <= conv_ovf;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
